// File: rtl/fp_soc_usb_evt_ctrl.sv
// -----------------------------------------------------------------------------
// fp_soc_usb_evt_ctrl
// Avalon-MM event controller for the MAX3421E side-band pins (bit0 GPX, bit1 INT).
// Each pin is synchronised, debounced against a programmable threshold, then
// edge-captured under a per-pin polarity. A maskable, registered level IRQ is
// raised towards the Nios II while any enabled capture flag is set.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (0 DATA, 1 MASK, 2 CAPTURE, 3 CFG)
//   chipselect  Avalon select
//   write_n     Avalon write strobe, active-low
//   writedata   Avalon write data
//   readdata    Avalon read data, registered (1-cycle latency)
//   in_port     raw asynchronous pins from the USB chip
//   irq         level interrupt, active-high, registered
// -----------------------------------------------------------------------------
module fp_soc_usb_evt_ctrl #(
   parameter int NUM_IN      = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DBNC_W      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [NUM_IN-1:0] in_port,
   output logic              irq
);

   localparam int CHAIN_W = SYNC_STAGES * NUM_IN;

   logic [CHAIN_W-1:0] sync_q;
   logic [NUM_IN-1:0]  sync_s;
   logic [NUM_IN-1:0]  filt;
   logic [NUM_IN-1:0]  edge_evt;

   logic [NUM_IN-1:0]  mask_q, mask_d;
   logic [NUM_IN-1:0]  cap_q, cap_d;
   logic [NUM_IN-1:0]  pol_q, pol_d;
   logic [DBNC_W-1:0]  dbnc_q, dbnc_d;
   logic [31:0]        readdata_q, readdata_d;
   logic               irq_q, irq_d;

   logic               wr_en;

   assign wr_en = chipselect & ~write_n;

   // Synchroniser: oldest stage sits in the top NUM_IN bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[CHAIN_W-NUM_IN-1:0], in_port};
      end
   end

   assign sync_s = sync_q[CHAIN_W-1 -: NUM_IN];

   // Per-input debounce. The counter only advances while the synchronised level
   // disagrees with the filtered level and stops at the threshold, so it never
   // wraps; a threshold lowered mid-count is honoured on the next compare.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [DBNC_W-1:0] cnt_q;
      logic              filt_q;
      logic              differ;
      logic              update;

      assign differ       = sync_s[gi] ^ filt_q;
      assign update       = differ && (cnt_q >= dbnc_q);
      assign filt[gi]     = filt_q;
      // POL=0 captures the rising update, POL=1 the falling one.
      assign edge_evt[gi] = update && (sync_s[gi] == ~pol_q[gi]);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
         end else if (!differ) begin
            cnt_q  <= '0;
         end else if (update) begin
            filt_q <= sync_s[gi];
            cnt_q  <= '0;
         end else begin
            cnt_q  <= cnt_q + {{(DBNC_W-1){1'b0}}, 1'b1};
         end
      end
   end

   always_comb begin
      mask_d     = mask_q;
      cap_d      = cap_q;
      pol_d      = pol_q;
      dbnc_d     = dbnc_q;
      readdata_d = '0;

      if (wr_en) begin
         case (address)
            2'd1: mask_d = writedata[NUM_IN-1:0];
            2'd2: cap_d  = cap_q & ~writedata[NUM_IN-1:0];
            2'd3: begin
               dbnc_d = writedata[DBNC_W-1:0];
               pol_d  = writedata[16 +: NUM_IN];
            end
            default: ;
         endcase
      end
      // Applied after the W1C so a same-cycle capture survives the clear.
      cap_d = cap_d | edge_evt;

      case (address)
         2'd0: readdata_d[NUM_IN-1:0] = filt;
         2'd1: readdata_d[NUM_IN-1:0] = mask_q;
         2'd2: readdata_d[NUM_IN-1:0] = cap_q;
         default: begin
            readdata_d[DBNC_W-1:0]  = dbnc_q;
            readdata_d[16 +: NUM_IN] = pol_q;
         end
      endcase

      irq_d = |(cap_q & mask_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q     <= '0;
         cap_q      <= '0;
         pol_q      <= '0;
         dbnc_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         pol_q      <= pol_d;
         dbnc_q     <= dbnc_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_fp_soc_usb_evt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_soc_usb_evt_ctrl
// Directed bench: a register-access vector table followed by hand-written
// sequences for debounce, capture, W1C, polarity, masking and reset corners.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fp_soc_usb_evt_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [1:0]  in_port;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [16];

   fp_soc_usb_evt_ctrl #(
      .NUM_IN     (2),
      .SYNC_STAGES(2),
      .DBNC_W     (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [1:0] a, input string name, input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      tick();
      chipselect = 1'b0;
      check(name, readdata, exp);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
      vecs[4]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
      vecs[5]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0003};
      vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
      vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h0003_00FF};
      vecs[8]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
      vecs[9]  = '{1'b0, 2'd0, 32'h0,        32'h0};
      vecs[10] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
      vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h0};
      vecs[12] = '{1'b1, 2'd3, 32'h0,        32'h0};
      vecs[13] = '{1'b0, 2'd3, 32'h0,        32'h0};
      vecs[14] = '{1'b1, 2'd1, 32'h0000_0003, 32'h0};
      vecs[15] = '{1'b0, 2'd1, 32'h0,        32'h0000_0003};

      reset_n    = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 2'b00;
      #2 reset_n = 1'b0;
      #1;
      check("reset readdata", readdata, 32'h0);
      check("reset irq", {31'h0, irq}, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Register map, unused-bit zeros.
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) begin
            bus_wr(vecs[i].addr, vecs[i].data);
         end else begin
            bus_rd(vecs[i].addr, $sformatf("vec%0d rd a%0d", i, vecs[i].addr), vecs[i].exp);
         end
      end

      // readdata is registered: changing address does not alter it until the edge.
      address = 2'd3;
      #2;
      check("rd latency hold", readdata, 32'h3);
      tick();
      check("rd latency update", readdata, 32'h0);

      // 1: D=0, POL=0, MASK=3; rise on GPX -> capture at edge 3, irq at edge 4.
      address = 2'd2;
      tick();
      in_port = 2'b01;
      tick(); tick(); tick();
      check("t1 cap before edge3", readdata, 32'h0);
      check("t1 irq at edge3", {31'h0, irq}, 32'h0);
      tick();
      check("t1 cap at edge3", readdata, 32'h1);
      check("t1 irq at edge4", {31'h0, irq}, 32'h1);
      bus_rd(2'd0, "t1 data", 32'h1);

      // 2: D=5; 4- and 5-clk glitches on INT are rejected.
      bus_wr(2'd2, 32'h1);
      bus_wr(2'd3, 32'h5);
      for (int len = 4; len <= 5; len++) begin
         in_port = 2'b11;
         repeat (len) tick();
         in_port = 2'b01;
         repeat (12) tick();
         bus_rd(2'd0, $sformatf("t2 data glitch%0d", len), 32'h1);
         bus_rd(2'd2, $sformatf("t2 cap glitch%0d", len), 32'h0);
         check($sformatf("t2 irq glitch%0d", len), {31'h0, irq}, 32'h0);
      end

      // 2b: 6-clk high passes; capture at edge 1+2+5=8, irq at edge 9.
      address = 2'd2;
      in_port = 2'b11;
      repeat (6) tick();
      in_port = 2'b01;
      repeat (2) tick();
      check("t2b irq at edge8", {31'h0, irq}, 32'h0);
      tick();
      check("t2b irq at edge9", {31'h0, irq}, 32'h1);
      check("t2b cap", readdata, 32'h2);
      repeat (12) tick();
      bus_rd(2'd0, "t2b data after fall", 32'h1);
      bus_rd(2'd2, "t2b cap kept", 32'h2);

      // 3: CAPTURE=3 then W1C bit by bit.
      bus_wr(2'd3, 32'h0);
      in_port = 2'b00;
      repeat (5) tick();
      in_port = 2'b01;
      repeat (5) tick();
      bus_rd(2'd2, "t3 cap both", 32'h3);
      check("t3 irq both", {31'h0, irq}, 32'h1);
      bus_wr(2'd2, 32'h1);
      bus_rd(2'd2, "t3 cap after w1c0", 32'h2);
      check("t3 irq after w1c0", {31'h0, irq}, 32'h1);
      bus_wr(2'd2, 32'h2);
      check("t3 irq registered", {31'h0, irq}, 32'h1);
      tick();
      check("t3 irq dropped", {31'h0, irq}, 32'h0);
      bus_rd(2'd2, "t3 cap cleared", 32'h0);

      // 4: capture on bit0 coincides with a W1C of bit0 -> set wins.
      in_port = 2'b00;
      repeat (5) tick();
      in_port = 2'b01;
      tick(); tick();
      address    = 2'd2;
      writedata  = 32'h1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      bus_rd(2'd2, "t4 set beats clear", 32'h1);

      // 5: POL=0b10, MASK=2; INT captures only on the fall.
      bus_wr(2'd1, 32'h2);
      bus_wr(2'd2, 32'h3);
      bus_wr(2'd3, 32'h0002_0000);
      bus_rd(2'd2, "t5 pol change no cap", 32'h0);
      in_port = 2'b11;
      repeat (6) tick();
      bus_rd(2'd2, "t5 cap on rise", 32'h0);
      check("t5 irq on rise", {31'h0, irq}, 32'h0);
      in_port = 2'b01;
      repeat (6) tick();
      bus_rd(2'd2, "t5 cap on fall", 32'h2);
      check("t5 irq on fall", {31'h0, irq}, 32'h1);
      bus_wr(2'd2, 32'h2);
      in_port = 2'b11;
      repeat (6) tick();
      bus_rd(2'd2, "t5 cap second rise", 32'h0);
      check("t5 irq second rise", {31'h0, irq}, 32'h0);

      // 5b: GPX rise with MASK[0]=0 -> captured, no irq.
      in_port = 2'b10;
      repeat (6) tick();
      bus_wr(2'd2, 32'h3);
      in_port = 2'b11;
      repeat (6) tick();
      bus_rd(2'd2, "t5b cap gpx", 32'h1);
      check("t5b irq masked", {31'h0, irq}, 32'h0);
      bus_rd(2'd0, "t5b data", 32'h3);

      // 6: reset mid-count with pins high; capture reappears SYNC_STAGES+1 edges after release.
      bus_wr(2'd3, 32'h5);
      in_port = 2'b00;
      repeat (3) tick();
      in_port = 2'b11;
      reset_n = 1'b0;
      #1;
      check("t6 async readdata", readdata, 32'h0);
      check("t6 async irq", {31'h0, irq}, 32'h0);
      address = 2'd2;
      repeat (3) tick();
      check("t6 readdata in reset", readdata, 32'h0);
      reset_n = 1'b1;
      tick(); tick(); tick();
      check("t6 cap before edge3", readdata, 32'h0);
      tick();
      check("t6 cap at edge3", readdata, 32'h3);
      check("t6 irq masked", {31'h0, irq}, 32'h0);
      bus_rd(2'd1, "t6 mask reset", 32'h0);
      bus_rd(2'd3, "t6 cfg reset", 32'h0);
      bus_rd(2'd0, "t6 data", 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
